// File: rtl/booth_pp_gen.sv
// Radix-4 Booth encoder and partial-product generator for the 16x16 signed multiplier.
// Two-stage valid/ready pipeline; rows use the sign-extension-encoded layout the Dadda tree expects.
module booth_pp_gen #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [19:0]      pp0,
  output logic [18:0]      pp1,
  output logic [18:0]      pp2,
  output logic [18:0]      pp3,
  output logic [18:0]      pp4,
  output logic [18:0]      pp5,
  output logic [18:0]      pp6,
  output logic [17:0]      pp7,
  output logic [7:0]       sign,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned OP_W   = 16;
  localparam int unsigned M_W    = OP_W + 1;
  localparam int unsigned W0_W   = OP_W + 2;
  localparam int unsigned ROWS   = 8;

  logic             s1_valid;
  logic [OP_W-1:0]  s1_a;
  logic [OP_W-1:0]  s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_ready;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  // Booth digit decode: one/two select the multiple magnitude, neg the sign
  logic [OP_W:0]   b_ext;
  logic [ROWS-1:0] d_one;
  logic [ROWS-1:0] d_two;
  logic [ROWS-1:0] d_neg;

  always_comb begin
    b_ext = {s1_b, 1'b0};
    d_one = '0;
    d_two = '0;
    d_neg = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: d_one[i] = 1'b1;
        3'b011:         d_two[i] = 1'b1;
        3'b100: begin
          d_two[i] = 1'b1;
          d_neg[i] = 1'b1;
        end
        3'b101, 3'b110: begin
          d_one[i] = 1'b1;
          d_neg[i] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Rows 1..7: one's-complemented multiple, the +1 travels on sign[i]
  logic [M_W-1:0] r [1:7];

  always_comb begin
    for (int i = 1; i < int'(ROWS); i++) begin
      logic [M_W-1:0] m;
      m = '0;
      if (d_one[i])      m = {s1_a[OP_W-1], s1_a};
      else if (d_two[i]) m = {s1_a, 1'b0};
      r[i] = m ^ {M_W{d_neg[i]}};
    end
  end

  // Row 0 is a true two's-complement product so -2 * -32768 stays exact
  logic [W0_W-1:0] a18;
  logic [W0_W-1:0] mag0;
  logic [W0_W-1:0] w0;

  always_comb begin
    a18  = {{2{s1_a[OP_W-1]}}, s1_a};
    mag0 = '0;
    if (d_one[0])      mag0 = a18;
    else if (d_two[0]) mag0 = W0_W'(a18 << 1);
    w0 = d_neg[0] ? W0_W'(-mag0) : mag0;
  end

  logic [19:0] pp0_d;
  logic [18:0] pp1_d, pp2_d, pp3_d, pp4_d, pp5_d, pp6_d;
  logic [17:0] pp7_d;
  logic [7:0]  sign_d;

  always_comb begin
    pp0_d  = {~w0[17], w0[17], w0[17], w0[16:0]};
    pp1_d  = {1'b1, ~r[1][16], r[1]};
    pp2_d  = {1'b1, ~r[2][16], r[2]};
    pp3_d  = {1'b1, ~r[3][16], r[3]};
    pp4_d  = {1'b1, ~r[4][16], r[4]};
    pp5_d  = {1'b1, ~r[5][16], r[5]};
    pp6_d  = {1'b1, ~r[6][16], r[6]};
    pp7_d  = {~r[7][16], r[7]};
    sign_d = {d_neg[7:1], 1'b0};
  end

  // Stage 2: registered partial-product set, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pp0       <= '0;
      pp1       <= '0;
      pp2       <= '0;
      pp3       <= '0;
      pp4       <= '0;
      pp5       <= '0;
      pp6       <= '0;
      pp7       <= '0;
      sign      <= '0;
      out_tag   <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        pp0     <= pp0_d;
        pp1     <= pp1_d;
        pp2     <= pp2_d;
        pp3     <= pp3_d;
        pp4     <= pp4_d;
        pp5     <= pp5_d;
        pp6     <= pp6_d;
        pp7     <= pp7_d;
        sign    <= sign_d;
        out_tag <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_gen.sv
// Bench for booth_pp_gen: rows are recombined by weight and compared with the plain product.
module tb_booth_pp_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] pp0;
  logic [18:0] pp1, pp2, pp3, pp4, pp5, pp6;
  logic [17:0] pp7;
  logic [7:0]  sign;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  booth_pp_gen #(.TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .pp0(pp0), .pp1(pp1), .pp2(pp2), .pp3(pp3), .pp4(pp4),
    .pp5(pp5), .pp6(pp6), .pp7(pp7),
    .sign(sign), .out_tag(out_tag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] prod;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [31:0] product(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 32'(p);
  endfunction

  // Rows and negate bits summed at their column weights, modulo 2^32
  function automatic logic [31:0] wsum();
    logic [63:0] rows [8];
    logic [63:0] s;
    rows[0] = 64'(pp0); rows[1] = 64'(pp1); rows[2] = 64'(pp2); rows[3] = 64'(pp3);
    rows[4] = 64'(pp4); rows[5] = 64'(pp5); rows[6] = 64'(pp6); rows[7] = 64'(pp7);
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + (rows[i] << (2*i)) + (64'(sign[i]) << (2*i));
    end
    return s[31:0];
  endfunction

  function automatic logic [191:0] snap();
    return 192'({out_valid, out_tag, sign, pp7, pp6, pp5, pp4, pp3, pp2, pp1, pp0});
  endfunction

  // Monitor: scoreboard on output transfers, stability while stalled
  logic         held = 1'b0;
  logic [191:0] prev_snap;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) chk("stall_hold", snap(), prev_snap);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", wsum(), e.prod);
          chk("tag_order", out_tag, e.tag);
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{prod: product(in_a, in_b), tag: in_tag});
      held      = out_valid && !out_ready;
      prev_snap = snap();
    end
  end

  // Offer one pair until accepted; returns #1 after the accepting edge
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
    int  n;
    logic acc;
    in_a = a; in_b = b; in_tag = t; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  // Single pair with a free downstream: checks latency and the recombined value
  task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                          input logic [31:0] exp_prod);
    out_ready = 1'b1;
    send(a, b, t);
    chk("lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", out_valid, 1);
    chk("dir_sum", wsum(), exp_prod);
    chk("dir_tag", out_tag, t);
    wait_drain();
  endtask

  logic [15:0] ext_vals [5] = '{16'h8000, 16'h7fff, 16'h0000, 16'hffff, 16'h0001};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_outs", snap(), 0);
    chk("reset_in_ready", in_ready, 1);

    // A=1, B=1: exact row values
    out_ready = 1'b1;
    send(16'd1, 16'd1, 4'h5);
    chk("lat_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("one_valid", out_valid, 1);
    chk("one_pp0", pp0, 20'h80001);
    chk("one_pp1_6", {pp1, pp2, pp3, pp4, pp5, pp6},
        {19'h60000, 19'h60000, 19'h60000, 19'h60000, 19'h60000, 19'h60000});
    chk("one_pp7", pp7, 18'h20000);
    chk("one_sign", sign, 8'h00);
    chk("one_tag", out_tag, 4'h5);
    wait_drain();

    // A=-32768, B=2: digit0 = -2 on the most negative multiplicand
    send(16'h8000, 16'd2, 4'h9);
    @(posedge clk);
    #1;
    chk("min2_pp0", pp0, 20'h90000);
    chk("min2_sign1", sign[1], 1'b0);
    chk("min2_sum", wsum(), 32'hffff0000);
    wait_drain();

    directed(16'h8000, 16'h8000, 4'h1, 32'h40000000);
    directed(16'h7fff, 16'h8000, 4'h2, 32'hc0008000);
    directed(16'h0000, 16'h5a3c, 4'h3, 32'h00000000);
    directed(16'h1234, 16'hffff, 4'h4, 32'hffffedcc);

    // Stall: downstream blocked, third pair must wait
    out_ready = 1'b0;
    send(16'd100, 16'hfff3, 4'ha);
    send(16'h8123, 16'h7777, 4'hb);
    in_a = 16'h0f0f; in_b = 16'hf0f0; in_tag = 4'hc; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    begin
      int n;
      logic acc;
      n = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 50);
      if (!acc) chk("stall_release", 0, 1);
    end
    in_valid = 1'b0;
    wait_drain();

    // Reset with two pairs in flight
    out_ready = 1'b0;
    send(16'h4321, 16'h1234, 4'hd);
    send(16'hbeef, 16'hcafe, 4'he);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_flush_outs", snap(), 0);
    chk("rst_in_ready", in_ready, 1);
    directed(16'hfedc, 16'h0123, 4'h7, product(16'hfedc, 16'h0123));

    // Randomized traffic with random backpressure
    begin
      int  accepted;
      int  cycles;
      logic acc;
      accepted = 0;
      cycles   = 0;
      acc      = 1'b1;
      while (accepted < 10000 && cycles < 60000) begin
        if (acc || !in_valid) begin
          in_a     = ($urandom_range(3) == 0) ? ext_vals[$urandom_range(4)] : 16'($urandom);
          in_b     = ($urandom_range(3) == 0) ? ext_vals[$urandom_range(4)] : 16'($urandom);
          in_tag   = 4'($urandom);
          in_valid = ($urandom_range(3) != 0);
        end
        out_ready = ($urandom_range(3) != 0);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) accepted++;
        @(posedge clk);
        #1;
        cycles++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("random_accepts", accepted, 10000);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
